// File: rtl/mem_arbiter.sv
// Shares the single main-memory port between icache refills and dcache refills/write-backs.
// Tie-break: fixed dcache priority by default; define MEM_ARB_RR_EN for round-robin.
module mem_arbiter #(
  parameter int unsigned MEM_LAT = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_req,
  input  logic [31:0]  i_addr,
  output logic         i_done,
  output logic [127:0] i_rdata,
  input  logic         d_req,
  input  logic         d_wr,
  input  logic [31:0]  d_addr,
  input  logic [127:0] d_wdata,
  output logic         d_done,
  output logic [127:0] d_rdata,
  output logic [31:0]  addr_mem,
  output logic         rd_mem,
  output logic         wr_mem,
  output logic [127:0] data_in_mem,
  input  logic [127:0] data_out_mem,
  output logic         busy,
  output logic         owner,
  output logic [11:0]  i_cnt,
  output logic [11:0]  d_cnt
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t         state, state_nxt;
  logic [3:0]     cnt;
  logic [27:0]    addr_lat;
  logic           wr_lat;
  logic [127:0]   wdata_lat;
  logic           grant_d;
  logic           start;
  logic           last;
  logic           unused_addr_bits;

  // Block addresses are line aligned; the byte offset is deliberately dropped.
  assign unused_addr_bits = ^{i_addr[3:0], d_addr[3:0]};

  assign start = (state == IDLE) && (i_req || d_req);
  assign last  = (state == BUSY) && (cnt == 4'd0);

  // Winner of the current IDLE cycle; only meaningful when start is high.
`ifdef MEM_ARB_RR_EN
  assign grant_d = d_req && (!i_req || !owner);
`else
  assign grant_d = d_req;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_req || d_req) state_nxt = BUSY;
      BUSY:    if (cnt == 4'd0)    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state != IDLE);
    rd_mem      = (state == BUSY) && !wr_lat;
    wr_mem      = (state == BUSY) && wr_lat;
    addr_mem    = (state == BUSY) ? {addr_lat, 4'b0} : 32'd0;
    data_in_mem = (state == BUSY) ? wdata_lat : 128'd0;
    i_done      = (state == DONE) && !owner;
    d_done      = (state == DONE) && owner;
  end

  // NOTE: sequential state uses non-blocking assignments only; the line registers
  // are reset too, since returned data must read as zero before any refill.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= 4'd0;
      owner     <= 1'b0;
      addr_lat  <= 28'd0;
      wr_lat    <= 1'b0;
      wdata_lat <= 128'd0;
      i_rdata   <= 128'd0;
      d_rdata   <= 128'd0;
      i_cnt     <= 12'd0;
      d_cnt     <= 12'd0;
    end else begin
      if (start) begin
        owner     <= grant_d;
        cnt       <= 4'(MEM_LAT - 1);
        addr_lat  <= grant_d ? d_addr[31:4] : i_addr[31:4];
        wr_lat    <= grant_d && d_wr;
        wdata_lat <= grant_d ? d_wdata : 128'd0;
      end else if (state == BUSY && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end

      // Completion: capture read data and bump the owner's saturating count.
      if (last) begin
        if (owner) begin
          if (!wr_lat)          d_rdata <= data_out_mem;
          if (d_cnt != 12'hFFF) d_cnt   <= d_cnt + 12'd1;
        end else begin
          if (!wr_lat)          i_rdata <= data_out_mem;
          if (i_cnt != 12'hFFF) i_cnt   <= i_cnt + 12'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed cases plus randomized traffic
// against a transaction-level model (arbitration rule, line memory, counters).
module tb_mem_arbiter;
  localparam int L = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         i_req = 1'b0, d_req = 1'b0, d_wr = 1'b0;
  logic [31:0]  i_addr = '0, d_addr = '0;
  logic [127:0] d_wdata = '0, data_out_mem = '0;
  logic         i_done, d_done, rd_mem, wr_mem, busy, owner;
  logic [127:0] i_rdata, d_rdata, data_in_mem;
  logic [31:0]  addr_mem;
  logic [11:0]  i_cnt, d_cnt;

  int checks = 0;
  int failures = 0;

  mem_arbiter #(.MEM_LAT(L)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .addr_mem(addr_mem), .rd_mem(rd_mem), .wr_mem(wr_mem),
    .data_in_mem(data_in_mem), .data_out_mem(data_out_mem),
    .busy(busy), .owner(owner), .i_cnt(i_cnt), .d_cnt(d_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Transaction-level model state.
  logic [127:0] mem_model [logic [27:0]];
  bit           m_owner;
  logic [11:0]  e_icnt, e_dcnt;
  logic [127:0] e_irdata, e_drdata;

  function automatic logic [127:0] mem_rd(input logic [27:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return {4{a, 4'h5}};
  endfunction

  function automatic logic [11:0] sat_inc(input logic [11:0] v);
    return (v == 12'd4095) ? v : v + 12'd1;
  endfunction

  task automatic model_reset();
    m_owner  = 1'b0;
    e_icnt   = '0;
    e_dcnt   = '0;
    e_irdata = '0;
    e_drdata = '0;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; i_req = 1'b0; d_req = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_outputs", {busy, owner, rd_mem, wr_mem, i_done, d_done, i_cnt, d_cnt}, '0);
    check("rst_rdata", i_rdata | d_rdata | data_in_mem | {96'd0, addr_mem}, '0);
    rst = 1'b1;
    model_reset();
  endtask

  // One full transaction, starting and ending at a negedge in IDLE.
  task automatic txn(input bit ir, input bit dr, input bit dw, input logic [31:0] ia,
                     input logic [31:0] da, input logic [127:0] wd, output bit win);
    bit           wr;
    logic [31:0]  ea;
    logic [127:0] line;
    check("idle_busy", busy, 0);
    i_req = ir; d_req = dr; d_wr = dw; i_addr = ia; d_addr = da; d_wdata = wd;
    if (ir && dr) begin
`ifdef MEM_ARB_RR_EN
      win = !m_owner;
`else
      win = 1'b1;
`endif
    end else begin
      win = dr;
    end
    wr   = win && dw;
    ea   = (win ? da : ia) & 32'hFFFF_FFF0;
    line = mem_rd(ea[31:4]);
    @(posedge clk);
    @(negedge clk);
    // Requester inputs wander after the grant; the latched request must stand.
    i_addr = ~ia; d_addr = ~da; d_wdata = ~wd; d_wr = ~dw;
    for (int k = 0; k < L; k++) begin
      check("busy", busy, 1);
      check("owner", owner, win);
      check("rd_mem", rd_mem, !wr);
      check("wr_mem", wr_mem, wr);
      check("addr_mem", addr_mem, ea);
      if (wr) check("data_in_mem", data_in_mem, wd);
      check("early_done", {i_done, d_done}, 0);
      data_out_mem = (k == L - 1) ? line : {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
    end
    if (wr) mem_model[ea[31:4]] = wd;
    else if (win) e_drdata = line;
    else e_irdata = line;
    if (win) e_dcnt = sat_inc(e_dcnt);
    else     e_icnt = sat_inc(e_icnt);
    m_owner = win;
    check("i_done", i_done, !win);
    check("d_done", d_done, win);
    check("done_strobes", {rd_mem, wr_mem, addr_mem}, 0);
    check("i_rdata", i_rdata, e_irdata);
    check("d_rdata", d_rdata, e_drdata);
    check("i_cnt", i_cnt, e_icnt);
    check("d_cnt", d_cnt, e_dcnt);
    i_req = 1'b0; d_req = 1'b0;
    data_out_mem = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    check("post_done", {busy, i_done, d_done}, 0);
    check("owner_hold", owner, win);
  endtask

  initial begin
    bit           w;
    bit           exp_order [4];
    logic [127:0] d_before;
    bit           got;

    do_reset();

    // Icache refill of 0x1234 with a known line.
    mem_model[28'h0000_123] = {16{8'hA5}};
    txn(1'b1, 1'b0, 1'b0, 32'h0000_1234, 32'h0, '0, w);
    check("t1_rdata", i_rdata, {16{8'hA5}});
    check("t1_icnt", i_cnt, 1);

    // Dcache write-back; the returned line must not move.
    d_before = d_rdata;
    txn(1'b0, 1'b1, 1'b1, 32'h0, 32'h0000_0040, {4{32'h1111_1111}}, w);
    check("t2_rdata_kept", d_rdata, d_before);
    txn(1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_0048, '0, w);
    check("t2_readback", d_rdata, {4{32'h1111_1111}});

    // Randomized mixed traffic.
    for (int n = 0; n < 40; n++) begin
      bit ir, dr;
      ir = 1'($urandom_range(0, 1));
      dr = 1'($urandom_range(0, 1));
      if (!ir && !dr) dr = 1'b1;
      txn(ir, dr, 1'($urandom_range(0, 1)),
          32'h100 + 32'($urandom_range(0, 255)), 32'h100 + 32'($urandom_range(0, 255)),
          {$urandom, $urandom, $urandom, $urandom}, w);
    end

    // Both requesting for four transactions from reset.
    do_reset();
`ifdef MEM_ARB_RR_EN
    exp_order = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_order = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    for (int t = 0; t < 4; t++) begin
      txn(1'b1, 1'b1, 1'b0, 32'h300 + 32'(t * 16), 32'h400 + 32'(t * 16), '0, w);
      check("tie_order", w, exp_order[t]);
    end
    check("tie_icnt", i_cnt, e_icnt);

    // Reset during BUSY cycle 3 drops the transaction.
    do_reset();
    i_req = 1'b1; i_addr = 32'h2000;
    @(posedge clk);
    repeat (3) @(negedge clk);
    i_req = 1'b0;
    check("mid_rd_before", rd_mem, 1);
    #1 rst = 1'b0;
    #1;
    check("mid_rd_async", rd_mem, 0);
    check("mid_busy_async", busy, 0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    for (int c = 0; c < L + 2; c++) begin
      check("mid_no_done", {busy, i_done, d_done}, 0);
      @(negedge clk);
    end
    check("mid_counters", {i_cnt, d_cnt}, 0);

    // Saturation of the icache transaction count.
    do_reset();
    for (int n = 0; n < 4096; n++) begin
      i_req = 1'b1;
      i_addr = $urandom;
      @(posedge clk);
      @(negedge clk);
      i_req = 1'b0;
      got = 1'b0;
      for (int c = 0; c < L + 2 && !got; c++) begin
        if (i_done) got = 1'b1;
        else @(negedge clk);
      end
      check("sat_done_seen", got, 1);
      e_icnt = sat_inc(e_icnt);
      if (n >= 4093) check("sat_icnt", i_cnt, e_icnt);
      @(negedge clk);
    end
    check("sat_final", i_cnt, 12'd4095);
    check("sat_dcnt", d_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
